// File: rtl/switch_db_multi.sv
// N-channel switch debouncer. Each channel verifies presses and releases, holds a
// debounced level, and can emit auto-repeat pulses while the switch stays held.
module switch_db_multi #(
    parameter int unsigned N             = 4,
    parameter int unsigned VERIFY_CNT    = 2,
    parameter int unsigned CNT_W         = 8,
    parameter int unsigned REPEAT_EN     = 1,
    parameter int unsigned REPEAT_DELAY  = 16,
    parameter int unsigned REPEAT_PERIOD = 4,
    parameter int unsigned RPT_W         = 16
) (
    input  logic         CLK,
    input  logic         ACLR,
    input  logic [N-1:0] SW,
    output logic [N-1:0] SWDB,
    output logic [N-1:0] SWREL,
    output logic [N-1:0] SWLVL,
    output logic [N-1:0] SWRPT
);

    typedef enum logic [1:0] {
        OFF  = 2'd0,
        EDGE = 2'd1,
        HOLD = 2'd2,
        RELV = 2'd3
    } state_e;

    localparam logic [CNT_W-1:0] VERIFY_L = CNT_W'(VERIFY_CNT);
    localparam logic [RPT_W-1:0] DELAY_L  = RPT_W'(REPEAT_DELAY);
    localparam logic [RPT_W-1:0] PERIOD_L = RPT_W'(REPEAT_PERIOD);

    genvar ch;
    generate
        for (ch = 0; ch < N; ch++) begin : g_ch
            state_e           state_q;
            logic [CNT_W-1:0] cnt_q;
            logic [RPT_W-1:0] rpt_q;
            logic             first_q;
            logic             db_q;
            logic             rel_q;
            logic             lvl_q;
            logic             rptp_q;

            logic [CNT_W-1:0] cnt_d;
            logic [RPT_W-1:0] rpt_d;
            logic [RPT_W-1:0] rpt_lim;

            assign cnt_d   = cnt_q + CNT_W'(1);
            assign rpt_d   = rpt_q + RPT_W'(1);
            assign rpt_lim = first_q ? DELAY_L : PERIOD_L;

            always_ff @(posedge CLK or posedge ACLR) begin
                if (ACLR) begin
                    state_q <= OFF;
                    cnt_q   <= '0;
                    rpt_q   <= '0;
                    first_q <= 1'b0;
                    db_q    <= 1'b0;
                    rel_q   <= 1'b0;
                    lvl_q   <= 1'b0;
                    rptp_q  <= 1'b0;
                end else begin
                    db_q   <= 1'b0;
                    rel_q  <= 1'b0;
                    rptp_q <= 1'b0;
                    unique case (state_q)
                        OFF: begin
                            if (SW[ch]) begin
                                state_q <= EDGE;
                                cnt_q   <= CNT_W'(1);
                            end
                        end
                        EDGE: begin
                            if (!SW[ch]) begin
                                state_q <= OFF;
                                cnt_q   <= '0;
                            end else if (cnt_d == VERIFY_L) begin
                                state_q <= HOLD;
                                db_q    <= 1'b1;
                                lvl_q   <= 1'b1;
                                cnt_q   <= '0;
                                rpt_q   <= '0;
                                first_q <= 1'b1;
                            end else begin
                                cnt_q <= cnt_d;
                            end
                        end
                        HOLD: begin
                            if (!SW[ch]) begin
                                state_q <= RELV;
                                cnt_q   <= CNT_W'(1);
                            end else if (REPEAT_EN != 0) begin
                                if (rpt_d == rpt_lim) begin
                                    rptp_q  <= 1'b1;
                                    rpt_q   <= '0;
                                    first_q <= 1'b0;
                                end else begin
                                    rpt_q <= rpt_d;
                                end
                            end
                        end
                        RELV: begin
                            // A bounce back high resumes the repeat schedule where it paused.
                            if (SW[ch]) begin
                                state_q <= HOLD;
                                cnt_q   <= '0;
                            end else if (cnt_d == VERIFY_L) begin
                                state_q <= OFF;
                                rel_q   <= 1'b1;
                                lvl_q   <= 1'b0;
                                cnt_q   <= '0;
                            end else begin
                                cnt_q <= cnt_d;
                            end
                        end
                        default: state_q <= OFF;
                    endcase
                end
            end

            assign SWDB[ch]  = db_q;
            assign SWREL[ch] = rel_q;
            assign SWLVL[ch] = lvl_q;
            assign SWRPT[ch] = rptp_q;
        end
    endgenerate

endmodule

// File: tb/tb_switch_db_multi.sv
// Directed bench for switch_db_multi: two channels, VERIFY_CNT=3, repeat 8/4,
// plus a repeat-disabled twin sharing the same stimulus.
module tb_switch_db_multi;

    logic       CLK;
    logic       ACLR;
    logic [1:0] SW;
    logic [1:0] SWDB, SWREL, SWLVL, SWRPT;
    logic [1:0] SWDB_n, SWREL_n, SWLVL_n, SWRPT_n;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    switch_db_multi #(
        .N(2), .VERIFY_CNT(3), .CNT_W(8), .REPEAT_EN(1),
        .REPEAT_DELAY(8), .REPEAT_PERIOD(4), .RPT_W(16)
    ) dut (
        .CLK(CLK), .ACLR(ACLR), .SW(SW),
        .SWDB(SWDB), .SWREL(SWREL), .SWLVL(SWLVL), .SWRPT(SWRPT)
    );

    switch_db_multi #(
        .N(2), .VERIFY_CNT(3), .CNT_W(8), .REPEAT_EN(0),
        .REPEAT_DELAY(8), .REPEAT_PERIOD(4), .RPT_W(16)
    ) dut_norpt (
        .CLK(CLK), .ACLR(ACLR), .SW(SW),
        .SWDB(SWDB_n), .SWREL(SWREL_n), .SWLVL(SWLVL_n), .SWRPT(SWRPT_n)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [1:0] got, input logic [1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%b exp=%b t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    logic [1:0] sw_seq  [6] = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00};
    logic [1:0] rel_seq [6] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01};
    logic [1:0] lvl_seq [6] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00};

    initial begin
        ACLR = 1'b1;
        SW   = 2'b11;

        // Reset held with switches pressed
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("rst_db",  SWDB,  2'b00);
            check_eq("rst_rel", SWREL, 2'b00);
            check_eq("rst_lvl", SWLVL, 2'b00);
            check_eq("rst_rpt", SWRPT, 2'b00);
        end
        ACLR = 1'b0;
        SW   = 2'b00;
        tick();
        check_eq("idle_lvl", SWLVL, 2'b00);

        // Glitch: two high samples then low
        SW = 2'b01;
        tick(); check_eq("gl_db1", SWDB, 2'b00);
        tick(); check_eq("gl_db2", SWDB, 2'b00);
        SW = 2'b00;
        tick();
        check_eq("gl_db3",  SWDB,  2'b00);
        check_eq("gl_lvl3", SWLVL, 2'b00);
        tick();
        check_eq("gl_lvl4", SWLVL, 2'b00);

        // Clean press on ch0 while ch1 glitches; press accepted on edge k+2
        SW = 2'b01;
        tick(); check_eq("pr_db_k", SWDB, 2'b00);
        SW = 2'b11;
        tick(); check_eq("pr_db_k1", SWDB, 2'b00);
        SW = 2'b01;
        tick();
        check_eq("pr_db_k2",  SWDB,  2'b01);
        check_eq("pr_lvl_k2", SWLVL, 2'b01);
        check_eq("pr_db_nr",  SWDB_n, 2'b01);
        tick();
        check_eq("pr_db_k3",  SWDB,  2'b00);
        check_eq("pr_lvl_k3", SWLVL, 2'b01);
        check_eq("pr_rpt_e1", SWRPT, 2'b00);

        // Auto-repeat at e0+8, e0+12, e0+16; disabled twin stays silent
        for (int t = 2; t <= 17; t++) begin
            tick();
            check_eq($sformatf("rp_rpt_e%0d", t), SWRPT,
                     (t == 8 || t == 12 || t == 16) ? 2'b01 : 2'b00);
            check_eq($sformatf("rp_nr_e%0d", t), SWRPT_n, 2'b00);
            check_eq($sformatf("rp_db_e%0d", t), SWDB, 2'b00);
        end

        // Release with one bounce: low, low, high, low, low, low
        for (int i = 0; i < 6; i++) begin
            SW = sw_seq[i];
            tick();
            check_eq($sformatf("rl_rel%0d", i), SWREL, rel_seq[i]);
            check_eq($sformatf("rl_lvl%0d", i), SWLVL, lvl_seq[i]);
            check_eq($sformatf("rl_db%0d", i),  SWDB,  2'b00);
            check_eq($sformatf("rl_rpt%0d", i), SWRPT, 2'b00);
        end
        tick();
        check_eq("rl_rel_after", SWREL, 2'b00);
        check_eq("rl_db_after",  SWDB,  2'b00);

        // Both channels pressed together, then ch1 released alone
        SW = 2'b11;
        tick(); check_eq("sim_db1", SWDB, 2'b00);
        tick(); check_eq("sim_db2", SWDB, 2'b00);
        tick();
        check_eq("sim_db3",  SWDB,  2'b11);
        check_eq("sim_lvl3", SWLVL, 2'b11);
        for (int t = 1; t <= 13; t++) begin
            SW = (t <= 3) ? 2'b11 : 2'b01;
            tick();
            check_eq($sformatf("sim_rel_e%0d", t), SWREL, (t == 6) ? 2'b10 : 2'b00);
            check_eq($sformatf("sim_lvl_e%0d", t), SWLVL, (t >= 6) ? 2'b01 : 2'b11);
            check_eq($sformatf("sim_rpt_e%0d", t), SWRPT,
                     (t == 8 || t == 12) ? 2'b01 : 2'b00);
            check_eq($sformatf("sim_nrel_e%0d", t), SWREL_n, (t == 6) ? 2'b10 : 2'b00);
            check_eq($sformatf("sim_nrpt_e%0d", t), SWRPT_n, 2'b00);
        end

        // Clear mid-HOLD: level drops without a clock edge, no release follows
        ACLR = 1'b1;
        #1;
        check_eq("clr_lvl_async",  SWLVL,   2'b00);
        check_eq("clr_nlvl_async", SWLVL_n, 2'b00);
        tick();
        ACLR = 1'b0;
        SW   = 2'b00;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq($sformatf("clr_rel%0d", i), SWREL, 2'b00);
            check_eq($sformatf("clr_lvl%0d", i), SWLVL, 2'b00);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
